uart_receiver: RTL

- UART receive path. Pairs with the existing transmitter: 8N1 framing, LSB first, idle-high line.
- Samples the asynchronous `rx` line using a 16x-oversampling clock-enable from the shared baud generator.
- Validates the start bit at mid-bit and samples each data bit at its centre.
- Presents the received byte to the host with a sticky ready flag that the host clears.

---
 rtl/uart_receiver.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receive path: 2-flop input synchronizer, oversampled start/data/stop
// sampling, and a sticky byte-ready flag with overrun and framing-error status.
module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 4
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       rx,
  input  logic       clken,
  input  logic       rdy_clr,
  output logic [7:0] data,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] scnt, scnt_nxt;
  logic [2:0]       bitpos, bitpos_nxt;
  logic [7:0]       scratch, scratch_nxt;
  logic             rx_meta, rx_s;
  logic             done;

  // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state   <= IDLE;
      scnt    <= '0;
      bitpos  <= '0;
      scratch <= '0;
    end else begin
      state   <= state_nxt;
      scnt    <= scnt_nxt;
      bitpos  <= bitpos_nxt;
      scratch <= scratch_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    scnt_nxt    = scnt;
    bitpos_nxt  = bitpos;
    scratch_nxt = scratch;
    done        = 1'b0;
    if (clken) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nxt = START;
            scnt_nxt  = '0;
          end
        end
        START: begin
          // Re-check the line at mid start bit; a high level means it was a glitch.
          if (scnt == HALF_LAST) begin
            scnt_nxt = '0;
            if (!rx_s) begin
              state_nxt  = DATA;
              bitpos_nxt = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            scnt_nxt = scnt + 1'b1;
          end
        end
        DATA: begin
          if (scnt == FULL_LAST) begin
            scratch_nxt[bitpos] = rx_s;
            scnt_nxt            = '0;
            if (bitpos == 3'd7) state_nxt = STOP;
            else                bitpos_nxt = bitpos + 1'b1;
          end else begin
            scnt_nxt = scnt + 1'b1;
          end
        end
        STOP: begin
          if (scnt == FULL_LAST) begin
            done      = 1'b1;
            state_nxt = IDLE;
            scnt_nxt  = '0;
          end else begin
            scnt_nxt = scnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          scnt_nxt  = '0;
        end
      endcase
    end
  end

  // Byte completion takes priority over a coincident host acknowledge.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      data      <= 8'h00;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (done) begin
      data      <= scratch;
      rdy       <= 1'b1;
      frame_err <= ~rx_s;
      overrun   <= rdy & ~rdy_clr;
    end else if (rdy_clr) begin
      rdy     <= 1'b0;
      overrun <= 1'b0;
    end
  end

  assign rx_busy = (state != IDLE);

endmodule
